multicycle_control: RTL and testbench

//  Moore FSM sequencing the multi-cycle MIPS datapath: PC, IR, shared memory, register file, ALU muxes.

---
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle MIPS datapath: fetch/decode/execute sequencing,
// memory handshake, retired-instruction counter and a sticky illegal-opcode trap.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ILLEGAL = 4'd10
  } ctrlState_e;

  ctrlState_e curState;
  ctrlState_e nextState;
  logic       retire;

  assign state = curState;

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      curState    <= FETCH;
      instr_count <= '0;
    end else begin
      curState <= nextState;
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  // Next-state decode and Moore outputs (FETCH/MEMWR also look at mem_ready)
  always_comb begin
    nextState   = FETCH;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;

    case (curState)
      FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        nextState = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        if (OpCode == OP_LW || OpCode == OP_SW) begin
          nextState = MEMADR;
        end else if (OpCode == OP_RTYPE) begin
          nextState = EXEC;
        end else if (OpCode == OP_BEQ) begin
          nextState = BRANCH;
        end else if (OpCode == OP_J) begin
          nextState = JUMP;
        end else begin
          nextState = ILLEGAL;
        end
      end
      MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nextState = (OpCode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead   = 1'b1;
        IorD      = 1'b1;
        nextState = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        retire   = 1'b1;
      end
      MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        retire    = mem_ready;
        nextState = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        nextState = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
      ILLEGAL: begin
        illegal_op = 1'b1;
        nextState  = ILLEGAL;
      end
      default: nextState = FETCH;
    endcase

    // Reset gates every strobe so an aborted instruction has no side effects
    if (rst) begin
      retire      = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemToReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench for multicycle_control: per-cycle expected state/strobes/counter
// are queued as each instruction is scheduled and compared as the FSM steps.
module tb_multicycle_control;

  localparam int unsigned TB_CNT_W = 4;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic                clk;
  logic                rst;
  logic [5:0]          OpCode;
  logic                mem_ready;
  logic                PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic                MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]          ALUSrcB, ALUOp, PCSource;
  logic [3:0]          state;
  logic                illegal_op;
  logic [TB_CNT_W-1:0] instr_count;

  multicycle_control #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ctlNow;
  assign ctlNow = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  typedef struct packed {
    logic [3:0]          s;
    logic                mr;
    logic [5:0]          op;
    logic [15:0]         ctl;
    logic                ill;
    logic [TB_CNT_W-1:0] cnt;
  } exp_t;

  exp_t                sb[$];
  logic [TB_CNT_W-1:0] modelCnt;
  int                  nRun;
  int                  nFail;

  // Expected control word for a state, same bit order as ctlNow
  function automatic logic [15:0] ctlOf(input logic [3:0] s, input logic mr);
    logic [15:0] c;
    c = '0;
    case (s)
      4'd0: begin c[15] = mr; c[12] = 1'b1; c[10] = mr; c[5:4] = 2'b01; end
      4'd1: c[5:4] = 2'b11;
      4'd2: begin c[6] = 1'b1; c[5:4] = 2'b10; end
      4'd3: begin c[12] = 1'b1; c[13] = 1'b1; end
      4'd4: begin c[7] = 1'b1; c[9] = 1'b1; end
      4'd5: begin c[11] = 1'b1; c[13] = 1'b1; end
      4'd6: begin c[6] = 1'b1; c[3:2] = 2'b10; end
      4'd7: begin c[7] = 1'b1; c[8] = 1'b1; end
      4'd8: begin c[6] = 1'b1; c[3:2] = 2'b01; c[14] = 1'b1; c[1:0] = 2'b01; end
      4'd9: begin c[15] = 1'b1; c[1:0] = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic pushCycle(input logic [3:0] s, input logic mr, input logic [5:0] op);
    exp_t e;
    e.s   = s;
    e.mr  = mr;
    e.op  = op;
    e.ctl = ctlOf(s, mr);
    e.ill = (s == 4'd10);
    e.cnt = modelCnt;
    sb.push_back(e);
    if (s == 4'd4 || s == 4'd7 || s == 4'd8 || s == 4'd9 || (s == 4'd5 && mr))
      modelCnt = modelCnt + TB_CNT_W'(1);
  endtask

  // Schedule one whole instruction with the given memory stall counts
  task automatic pushInstr(input logic [5:0] op, input int fStall, input int mStall);
    for (int i = 0; i < fStall; i++) pushCycle(4'd0, 1'b0, op);
    pushCycle(4'd0, 1'b1, op);
    pushCycle(4'd1, 1'b1, op);
    case (op)
      OP_LW: begin
        pushCycle(4'd2, 1'b1, op);
        for (int i = 0; i < mStall; i++) pushCycle(4'd3, 1'b0, op);
        pushCycle(4'd3, 1'b1, op);
        pushCycle(4'd4, 1'b1, op);
      end
      OP_SW: begin
        pushCycle(4'd2, 1'b1, op);
        for (int i = 0; i < mStall; i++) pushCycle(4'd5, 1'b0, op);
        pushCycle(4'd5, 1'b1, op);
      end
      OP_R: begin
        pushCycle(4'd6, 1'b1, op);
        pushCycle(4'd7, 1'b1, op);
      end
      OP_BEQ: pushCycle(4'd8, 1'b1, op);
      OP_J:   pushCycle(4'd9, 1'b1, op);
      default: for (int i = 0; i < 20; i++) pushCycle(4'd10, 1'(i % 2), op);
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      OpCode = 6'($urandom_range(0, 63));
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      nRun++;
      if ({ctlNow, illegal_op, state, instr_count} !== {16'h0, 1'b0, 4'd0, TB_CNT_W'(0)}) begin
        nFail++;
        $display("FAIL reset cyc%0d: ctl=%h ill=%b state=%0d cnt=%0d, want ctl=0000 ill=0 state=0 cnt=0",
                 i, ctlNow, illegal_op, state, instr_count);
      end
    end
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    nRun++;
    if (MemRead !== 1'b1 || ALUSrcB !== 2'b01 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
      nFail++;
      $display("FAIL reset_release: MemRead=%b ALUSrcB=%b IRWrite=%b PCWrite=%b, want 1 01 0 0",
               MemRead, ALUSrcB, IRWrite, PCWrite);
    end
    modelCnt = '0;
  endtask

  task automatic test_rtype();
    exp_t e;
    pushInstr(OP_R, 0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); OpCode = e.op; mem_ready = e.mr; #1;
      nRun++;
      if ({state, ctlNow, illegal_op, instr_count} !== {e.s, e.ctl, e.ill, e.cnt}) begin
        nFail++;
        $display("FAIL rtype: state=%0d/%0d ctl=%h/%h ill=%b/%b cnt=%0d/%0d (got/want)",
                 state, e.s, ctlNow, e.ctl, illegal_op, e.ill, instr_count, e.cnt);
      end
    end
  endtask

  task automatic test_lw_stall();
    exp_t e;
    pushInstr(OP_LW, 0, 3);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); OpCode = e.op; mem_ready = e.mr; #1;
      nRun++;
      if ({state, ctlNow, illegal_op, instr_count} !== {e.s, e.ctl, e.ill, e.cnt}) begin
        nFail++;
        $display("FAIL lw_stall: state=%0d/%0d ctl=%h/%h ill=%b/%b cnt=%0d/%0d (got/want)",
                 state, e.s, ctlNow, e.ctl, illegal_op, e.ill, instr_count, e.cnt);
      end
    end
  endtask

  task automatic test_sw();
    exp_t e;
    pushInstr(OP_SW, 0, 0);
    pushInstr(OP_SW, 2, 2);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); OpCode = e.op; mem_ready = e.mr; #1;
      nRun++;
      if ({state, ctlNow, illegal_op, instr_count} !== {e.s, e.ctl, e.ill, e.cnt}) begin
        nFail++;
        $display("FAIL sw: state=%0d/%0d ctl=%h/%h ill=%b/%b cnt=%0d/%0d (got/want)",
                 state, e.s, ctlNow, e.ctl, illegal_op, e.ill, instr_count, e.cnt);
      end
    end
  endtask

  task automatic test_branch_jump();
    exp_t e;
    pushInstr(OP_BEQ, 0, 0);
    pushInstr(OP_J, 1, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); OpCode = e.op; mem_ready = e.mr; #1;
      nRun++;
      if ({state, ctlNow, illegal_op, instr_count} !== {e.s, e.ctl, e.ill, e.cnt}) begin
        nFail++;
        $display("FAIL branch_jump: state=%0d/%0d ctl=%h/%h ill=%b/%b cnt=%0d/%0d (got/want)",
                 state, e.s, ctlNow, e.ctl, illegal_op, e.ill, instr_count, e.cnt);
      end
    end
  endtask

  task automatic test_illegal_and_reset();
    exp_t e;
    pushInstr(OP_BAD, 0, 0);
    for (int pass = 0; pass < 2; pass++) begin
      while (sb.size() != 0) begin
        e = sb.pop_front();
        @(negedge clk); OpCode = e.op; mem_ready = e.mr; #1;
        nRun++;
        if ({state, ctlNow, illegal_op, instr_count} !== {e.s, e.ctl, e.ill, e.cnt}) begin
          nFail++;
          $display("FAIL illegal_p%0d: state=%0d/%0d ctl=%h/%h ill=%b/%b cnt=%0d/%0d (got/want)",
                   pass, state, e.s, ctlNow, e.ctl, illegal_op, e.ill, instr_count, e.cnt);
        end
      end
      // Abort whatever is in flight with a one-cycle reset
      @(negedge clk); rst = 1'b1; mem_ready = 1'b1; #1;
      nRun++;
      if (ctlNow !== 16'h0 || illegal_op !== 1'b0) begin
        nFail++;
        $display("FAIL abort_p%0d: ctl=%h ill=%b, want 0000 0", pass, ctlNow, illegal_op);
      end
      @(negedge clk); #1;
      nRun++;
      if (state !== 4'd0 || instr_count !== TB_CNT_W'(0) || illegal_op !== 1'b0) begin
        nFail++;
        $display("FAIL after_reset_p%0d: state=%0d cnt=%0d ill=%b, want 0 0 0",
                 pass, state, instr_count, illegal_op);
      end
      rst = 1'b0;
      mem_ready = 1'b0;
      modelCnt = '0;
      // Second pass: an lw caught while waiting in MEMRD
      if (pass == 0) begin
        pushInstr(OP_R, 0, 0);
        pushCycle(4'd0, 1'b1, OP_LW);
        pushCycle(4'd1, 1'b1, OP_LW);
        pushCycle(4'd2, 1'b1, OP_LW);
        pushCycle(4'd3, 1'b0, OP_LW);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [5:0] ops [5];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J};
    for (int k = 0; k < 24; k++)
      pushInstr(ops[$urandom_range(0, 4)], $urandom_range(0, 2), $urandom_range(0, 2));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); OpCode = e.op; mem_ready = e.mr; #1;
      nRun++;
      if ({state, ctlNow, illegal_op, instr_count} !== {e.s, e.ctl, e.ill, e.cnt}) begin
        nFail++;
        $display("FAIL back_to_back: state=%0d/%0d ctl=%h/%h ill=%b/%b cnt=%0d/%0d (got/want)",
                 state, e.s, ctlNow, e.ctl, illegal_op, e.ill, instr_count, e.cnt);
      end
    end
  endtask

  initial begin
    nRun      = 0;
    nFail     = 0;
    modelCnt  = '0;
    rst       = 1'b1;
    OpCode    = '0;
    mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw();
    test_branch_jump();
    test_illegal_and_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
